mod_mul_il: RTL and testbench

MOD_MUL_IL -- requirements
Module: mod_mul_il

---
 rtl/mod_arith_pkg.sv | 15 +
 rtl/mod_dbl_add.sv | 27 ++
 rtl/mod_mul_il.sv | 80 ++++++++
 tb/tb_mod_mul_il.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared types and constants for the interleaved modular multiplier
package mod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 256;

  localparam logic [255:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/mod_dbl_add.sv
// rtl/mod_dbl_add.sv - one interleaved step: acc_nxt = (2*acc + a_bit*b) mod m
module mod_dbl_add #(
  parameter int W = 256
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  input  logic         a_bit,
  output logic [W-1:0] acc_nxt
);

  logic [W:0] t;
  logic [W:0] mx;

  // With acc, b < m every intermediate stays below 2*m, so one extra bit suffices
  always_comb begin
    mx = {1'b0, m};
    t  = {acc, 1'b0};
    if (t >= mx) t = t - mx;
    if (a_bit) begin
      t = t + {1'b0, b};
      if (t >= mx) t = t - mx;
    end
    acc_nxt = t[W-1:0];
  end

endmodule

// File: rtl/mod_mul_il.sv
// rtl/mod_mul_il.sv - sequential (a*b) mod m, one multiplicand bit per cycle, MSB first
module mod_mul_il
  import mod_arith_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  state_t        state, state_nxt;
  logic [W-1:0]  a_r, b_r, m_r, acc, acc_step;
  logic [CW-1:0] cnt;
  logic          accept, range_bad, last;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign range_bad = (m < W'(2)) || (a >= m) || (b >= m);
  assign last      = (cnt == '0);

  mod_dbl_add #(.W(W)) u_step (
    .acc     (acc),
    .b       (b_r),
    .m       (m_r),
    .a_bit   (a_r[cnt]),
    .acc_nxt (acc_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = range_bad ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? (range_bad ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      if (accept) begin
        a_r <= a;
        b_r <= b;
        m_r <= m;
        acc <= '0;
        cnt <= CW'(W - 1);
        err <= range_bad;
        if (range_bad) result <= '0;
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= last ? '0 : cnt - 1'b1;
        // Capture the final step directly so result is valid in the DONE cycle
        if (last) result <= acc_step;
      end
    end
  end

endmodule

// File: tb/tb_mod_mul_il.sv
// tb/tb_mod_mul_il.sv - directed and swept checks of mod_mul_il at W=8, 16 and 256
module tb_mod_mul_il;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, busy8, done8, err8;
  logic [7:0]  a8, b8, m8, result8;
  logic        start16, busy16, done16, err16;
  logic [15:0] a16, b16, m16, result16;
  logic         start256, busy256, done256, err256;
  logic [255:0] a256, b256, m256, result256;

  mod_mul_il #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .m(m8),
    .busy(busy8), .done(done8), .result(result8), .err(err8)
  );
  mod_mul_il #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .m(m16),
    .busy(busy16), .done(done16), .result(result16), .err(err16)
  );
  mod_mul_il #(.W(256)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .a(a256), .b(b256), .m(m256),
    .busy(busy256), .done(done256), .result(result256), .err(err256)
  );

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  int vectors = 0;
  int miscompares = 0;
  int cur = 8;

  logic         sel_done, sel_busy, sel_err;
  logic [255:0] sel_res;

  always_comb begin
    sel_done = done256;
    sel_busy = busy256;
    sel_err  = err256;
    sel_res  = result256;
    if (cur == 8) begin
      sel_done = done8; sel_busy = busy8; sel_err = err8; sel_res = {248'b0, result8};
    end else if (cur == 16) begin
      sel_done = done16; sel_busy = busy16; sel_err = err16; sel_res = {240'b0, result16};
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic [255:0] ta, input logic [255:0] tb_,
                       input logic [255:0] tm, input logic s);
    if (w == 8) begin
      a8 = ta[7:0]; b8 = tb_[7:0]; m8 = tm[7:0]; start8 = s;
    end else if (w == 16) begin
      a16 = ta[15:0]; b16 = tb_[15:0]; m16 = tm[15:0]; start16 = s;
    end else begin
      a256 = ta; b256 = tb_; m256 = tm; start256 = s;
    end
  endtask

  task automatic stop_start(input int w);
    if (w == 8) start8 = 1'b0;
    else if (w == 16) start16 = 1'b0;
    else start256 = 1'b0;
  endtask

  // Starts an op (in the current cycle when b2b, else in the next one), checks
  // busy high and done low until exactly the expected done cycle.
  task automatic run_op(input string tag, input int w, input logic b2b,
                        input logic [255:0] ta, input logic [255:0] tb_,
                        input logic [255:0] tm, input logic [255:0] er, input logic ee);
    int lat;
    logic bad;
    cur = w;
    lat = ee ? 1 : w + 1;
    bad = 1'b0;
    if (!b2b) @(negedge clk);
    drive(w, ta, tb_, tm, 1'b1);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) stop_start(w);
      if (c < lat && (sel_done !== 1'b0 || sel_busy !== 1'b1)) bad = 1'b1;
    end
    chk({tag, " timing"}, {255'b0, bad}, 256'd0);
    chk({tag, " done"}, {255'b0, sel_done}, 256'd1);
    chk({tag, " busy"}, {255'b0, sel_busy}, 256'd0);
    chk({tag, " err"}, {255'b0, sel_err}, {255'b0, ee});
    chk({tag, " result"}, sel_res, er);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic bad;
    logic [255:0] ra, rb, rm, rexp;
    logic [511:0] prod, rem;
    logic [63:0]  e16;

    rst = 1'b1;
    drive(8, 256'd0, 256'd0, 256'd0, 1'b1);
    drive(16, 256'd0, 256'd0, 256'd0, 1'b0);
    drive(256, 256'd0, 256'd0, 256'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset w8", {busy8, done8, err8, result8}, 256'd0);
    chk("reset w16", {busy16, done16, err16, result16}, 256'd0);
    chk("reset w256", {253'b0, busy256, done256, err256}, 256'd0);
    chk("reset w256 result", result256, 256'd0);
    rst = 1'b0;
    start8 = 1'b0;
    @(negedge clk);

    run_op("w8 200*100", 8, 1'b0, 256'd200, 256'd100, 256'd251, 256'd171, 1'b0);
    run_op("w8 254*254 m255", 8, 1'b0, 256'd254, 256'd254, 256'd255, 256'd1, 1'b0);
    run_op("w8 1*1 m2", 8, 1'b0, 256'd1, 256'd1, 256'd2, 256'd1, 1'b0);
    run_op("w8 0*0", 8, 1'b0, 256'd0, 256'd0, 256'd251, 256'd0, 1'b0);
    run_op("w8 a>=m", 8, 1'b0, 256'd251, 256'd5, 256'd251, 256'd0, 1'b1);
    run_op("w8 m=1", 8, 1'b0, 256'd0, 256'd0, 256'd1, 256'd0, 1'b1);
    run_op("w8 b>=m", 8, 1'b0, 256'd1, 256'd7, 256'd7, 256'd0, 1'b1);
    run_op("w8 m=0", 8, 1'b0, 256'd0, 256'd0, 256'd0, 256'd0, 1'b1);
    run_op("w16 max", 16, 1'b0, 256'd65520, 256'd65520, 256'd65521, 256'd1, 1'b0);
    run_op("w256 (p-1)^2", 256, 1'b0, P - 1, P - 1, P, 256'd1, 1'b0);
    run_op("w256 0*(p-1)", 256, 1'b0, 256'd0, P - 1, P, 256'd0, 1'b0);

    // Back-to-back: second start issued in the first op's DONE cycle
    run_op("b2b first", 8, 1'b0, 256'd3, 256'd4, 256'd7, 256'd5, 1'b0);
    run_op("b2b second", 8, 1'b1, 256'd6, 256'd6, 256'd7, 256'd1, 1'b0);
    run_op("err then legal", 8, 1'b1, 256'd9, 256'd1, 256'd7, 256'd0, 1'b1);
    run_op("legal after err", 8, 1'b1, 256'd5, 256'd3, 256'd7, 256'd1, 1'b0);

    // Start pulsed mid-RUN with different operands must be ignored
    cur = 8;
    bad = 1'b0;
    @(negedge clk);
    drive(8, 256'd3, 256'd4, 256'd7, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c == 3) drive(8, 256'd6, 256'd6, 256'd7, 1'b1);
      if (c == 4) start8 = 1'b0;
      if (c < 9 && done8 !== 1'b0) bad = 1'b1;
    end
    chk("midrun timing", {255'b0, bad}, 256'd0);
    chk("midrun done", {255'b0, done8}, 256'd1);
    chk("midrun result", {248'b0, result8}, 256'd5);

    // Reset during RUN aborts with no done pulse
    @(negedge clk);
    drive(8, 256'd6, 256'd6, 256'd7, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outputs", {busy8, done8, err8, result8}, 256'd0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 !== 1'b0 || busy8 !== 1'b0) bad = 1'b1;
    end
    chk("abort no done", {255'b0, bad}, 256'd0);
    run_op("after abort", 8, 1'b0, 256'd6, 256'd6, 256'd7, 256'd1, 1'b0);

    // Swept operands against wide-arithmetic reference
    for (int i = 0; i < 600; i++) begin
      rm = {240'b0, 16'($urandom_range(65535, 2))};
      ra = {240'b0, 16'($urandom % rm[15:0])};
      rb = {240'b0, 16'($urandom % rm[15:0])};
      e16 = ({48'b0, ra[15:0]} * {48'b0, rb[15:0]}) % {48'b0, rm[15:0]};
      run_op("sweep w16", 16, (i % 7) == 3, ra, rb, rm, {192'b0, e16}, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) rm = P;
      else begin
        rm = rnd256();
        rm[255] = (i % 4) == 1;
        if (rm < 256'd2) rm = 256'd2;
      end
      ra = rnd256() % rm;
      rb = rnd256() % rm;
      prod = {256'b0, ra} * {256'b0, rb};
      rem = prod % {256'b0, rm};
      rexp = rem[255:0];
      run_op("sweep w256", 256, (i % 5) == 2, ra, rb, rm, rexp, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
